// File: rtl/fpmul_src.sv
// Operand source for a floating-point multiplier: generates LFSR-based IEEE-754
// operand pairs, drives them over a valid/ready port and folds the products into a signature.
module fpmul_src #(
  parameter int unsigned N_TXN   = 16,
  parameter logic [31:0] SEED    = 32'hACE1_2345,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic [31:0] res_i,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] txn_cnt,
  output logic [31:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN_A    = 3'd1,
    S_GEN_B    = 3'd2,
    S_SEND     = 3'd3,
    S_WAIT_RES = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] N_TXN_W   = 16'(N_TXN);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_r;
  logic [31:0] lfsr_r;
  logic [15:0] wait_r;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  // Keep operands finite and normal: no Inf/NaN and no zero/denormal exponents.
  function automatic logic [31:0] sanitise(input logic [31:0] v);
    logic [7:0] e;
    e = (v[30:23] == 8'hFF) ? 8'hFE :
        (v[30:23] == 8'h00) ? 8'h01 : v[30:23];
    return {v[31], e, v[22:0]};
  endfunction

  // Sequencer: operand generation, both handshakes, capture and timeout supervision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      lfsr_r      <= SEED;
      wait_r      <= 16'd0;
      a_o         <= 32'd0;
      b_o         <= 32'd0;
      in_valid_o  <= 1'b0;
      res_ready_o <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      txn_cnt     <= 16'd0;
      signature   <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r     <= S_GEN_A;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            txn_cnt     <= 16'd0;
            signature   <= 32'd0;
            wait_r      <= 16'd0;
          end
        end
        S_GEN_A: begin
          a_o     <= sanitise(lfsr_r);
          lfsr_r  <= lfsr_step(lfsr_r);
          state_r <= S_GEN_B;
        end
        S_GEN_B: begin
          b_o        <= sanitise(lfsr_r);
          lfsr_r     <= lfsr_step(lfsr_r);
          in_valid_o <= 1'b1;
          wait_r     <= 16'd0;
          state_r    <= S_SEND;
        end
        S_SEND: begin
          if (in_valid_o && in_ready_i) begin
            in_valid_o  <= 1'b0;
            res_ready_o <= 1'b1;
            wait_r      <= 16'd0;
            state_r     <= S_WAIT_RES;
          end else if (wait_r == WAIT_LAST) begin
            in_valid_o  <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        S_WAIT_RES: begin
          if (res_valid_i && res_ready_o) begin
            res_ready_o <= 1'b0;
            signature   <= {signature[30:0], signature[31]} ^ res_i;
            txn_cnt     <= txn_cnt + 16'd1;
            if (16'(txn_cnt + 16'd1) == N_TXN_W) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              state_r <= S_GEN_A;
            end
          end else if (wait_r == WAIT_LAST) begin
            res_ready_o <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_valid_o  <= 1'b0;
          res_ready_o <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_src.sv
// Scoreboard bench for fpmul_src: a responder plays the multiplier, a model predicts
// operands and signature, and a monitor compares every operand transfer.
module tb_fpmul_src;

  localparam int          N_TXN      = 16;
  localparam int          TIMEOUT    = 64;
  localparam logic [31:0] SEED       = 32'hACE1_2345;
  localparam int          RESP_DELAY = 5;

  logic        clk = 1'b0;
  logic        rst_n, start, in_ready_i, res_valid_i;
  logic [31:0] res_i;
  logic [31:0] a_o, b_o, signature;
  logic        in_valid_o, res_ready_o, busy, done, timeout_err;
  logic [15:0] txn_cnt;

  fpmul_src #(.N_TXN(N_TXN), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a_o), .b_o(b_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .res_i(res_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .txn_cnt(txn_cnt), .signature(signature)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [31:0] lfsr_m, sig_m;
  int          txn_m;
  logic [63:0] exp_q[$];
  int  stall_left = 0, wcnt = 0;
  bit  glitch_send = 1'b0, resp_en = 1'b1, resp_rand = 1'b0;
  bit  in_seen = 1'b0;
  logic [31:0] hold_a, hold_b;
  logic [63:0] pair_e;
  int  send_cyc = 0, first_send_cyc = 0, pairs_run = 0, caps_run = 0, wait_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] m_sanitise(input logic [31:0] v);
    logic [7:0] e;
    e = v[30:23];
    if (e == 8'd255) e = 8'd254;
    else if (e == 8'd0) e = 8'd1;
    return {v[31], e, v[22:0]};
  endfunction

  function automatic logic [63:0] gen_pair();
    logic [31:0] a, b;
    a = m_sanitise(lfsr_m); lfsr_m = m_step(lfsr_m);
    b = m_sanitise(lfsr_m); lfsr_m = m_step(lfsr_m);
    return {a, b};
  endfunction

  // Multiplier stand-in: ready stalls, delayed products, stray valid during SEND.
  initial begin
    in_ready_i = 1'b1; res_valid_i = 1'b0; res_i = 32'd0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        res_valid_i = 1'b0; in_ready_i = 1'b1; wcnt = 0;
      end else begin
        if (in_valid_o && stall_left > 0) begin in_ready_i = 1'b0; stall_left--; end
        else in_ready_i = 1'b1;
        if (res_valid_i) res_valid_i = 1'b0;
        else if (res_ready_o && resp_en) begin
          if (wcnt == RESP_DELAY - 1) begin
            res_i = resp_rand ? $urandom() : 32'h3F80_0000;
            res_valid_i = 1'b1;
            wcnt = 0;
            sig_m = {sig_m[30:0], sig_m[31]} ^ res_i;
            txn_m++;
            if (txn_m < N_TXN) exp_q.push_back(gen_pair());
          end else wcnt++;
        end else if (glitch_send && in_valid_o) begin
          res_i = 32'hDEAD_BEEF; res_valid_i = 1'b1; glitch_send = 1'b0;
        end else wcnt = 0;
      end
    end
  end

  // Monitor: operand transfers against the scoreboard, stability while stalled, exclusivity.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) in_seen = 1'b0;
      else begin
        chk("valid_ready_exclusive", 32'(in_valid_o & res_ready_o), 32'd0);
        if (in_valid_o) begin
          if (!in_seen) begin hold_a = a_o; hold_b = b_o; in_seen = 1'b1; send_cyc = 0; end
          else begin chk("a_stable", a_o, hold_a); chk("b_stable", b_o, hold_b); end
          send_cyc++;
          if (in_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_pair", 32'd1, 32'd0);
            else begin
              pair_e = exp_q.pop_front();
              chk("a_o", a_o, pair_e[63:32]);
              chk("b_o", b_o, pair_e[31:0]);
            end
            if (pairs_run == 0) first_send_cyc = send_cyc;
            pairs_run++; in_seen = 1'b0; wait_cyc = 0;
          end
        end
        if (res_ready_o) wait_cyc++;
        if (res_ready_o && res_valid_i) caps_run++;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #2;
    start = 1'b1;
    txn_m = 0; sig_m = 32'd0; pairs_run = 0; caps_run = 0; first_send_cyc = 0;
    exp_q.push_back(gen_pair());
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin @(negedge clk); i++; end
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic check_full_run(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_txn_cnt"}, 32'(txn_cnt), 32'(N_TXN));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_signature"}, signature, sig_m);
    chk({tag, "_pairs"}, 32'(pairs_run), 32'(N_TXN));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_o"}, a_o, 32'd0);
    chk({tag, "_b_o"}, b_o, 32'd0);
    chk({tag, "_in_valid"}, 32'(in_valid_o), 32'd0);
    chk({tag, "_res_ready"}, 32'(res_ready_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_txn_cnt"}, 32'(txn_cnt), 32'd0);
    chk({tag, "_signature"}, signature, 32'd0);
  endtask

  initial begin
    int i;
    rst_n = 1'b0; start = 1'b0;
    lfsr_m = SEED; sig_m = 32'd0; txn_m = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_without_start", 32'(busy), 32'd0);

    // Run 1: ready tied high, constant 1.0 products.
    do_start();
    i = 0;
    while (!in_valid_o && i < 20) begin @(negedge clk); i++; end
    chk("first_a_is_seed", a_o, 32'hACE1_2345);
    chk("first_b_is_step", b_o, m_sanitise(m_step(SEED)));
    wait_done(1000);
    check_full_run("run1");

    // Run 2: 10-cycle ready stall, stray product in SEND, start while busy, random products.
    stall_left = 10; glitch_send = 1'b1; resp_rand = 1'b1;
    do_start();
    repeat (30) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    wait_done(1000);
    chk("stall_transfer_cycle", 32'(first_send_cyc), 32'd11);
    check_full_run("run2");

    // Run 3: no product ever returned.
    resp_en = 1'b0;
    do_start();
    wait_done(300);
    chk("to_timeout_err", 32'(timeout_err), 32'd1);
    chk("to_res_ready", 32'(res_ready_o), 32'd0);
    chk("to_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("to_wait_cycles", 32'(wait_cyc), 32'(TIMEOUT));
    chk("to_pairs", 32'(pairs_run), 32'd1);
    chk("to_captures", 32'(caps_run), 32'd0);

    // Run 4: reset during WAIT_RES of transaction 3, then a clean run.
    resp_en = 1'b1;
    do_start();
    i = 0;
    while (!(res_ready_o && caps_run == 2) && i < 500) begin @(negedge clk); i++; end
    chk("reached_txn3_wait", 32'(res_ready_o && caps_run == 2), 32'd1);
    resp_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    lfsr_m = SEED; sig_m = 32'd0; txn_m = 0; exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    chk("post_reset_no_capture", 32'(txn_cnt), 32'd0);
    resp_en = 1'b1;
    do_start();
    wait_done(1000);
    check_full_run("run4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
